// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush control slice.
// Register-address width, the zero register and the hazard FSM encoding.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [1:0] ctrl_state_t;

  localparam ctrl_state_t RUN      = 2'd0;
  localparam ctrl_state_t MEM_WAIT = 2'd1;
  localparam ctrl_state_t ERR      = 2'd2;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator.
// Flags an ID source that matches the destination of a load in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_MemRead,
  input  logic [REG_ADDR_W-1:0] ex_Rfile_wn,
  output logic                  lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ex_Rfile_wn == id_rs);
  assign rt_hit = id_uses_rt & (ex_Rfile_wn == id_rt);

  // $0 never carries a real dependency
  assign lu = ex_MemRead
            & (ex_Rfile_wn != REG_ZERO)
            & (rs_hit | rt_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (load-use, MEM wait, branch).
// Define PIPE_HAZARD_PERF_EN to add stall_cycles/flush_count counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_MemRead,
  input  logic [REG_ADDR_W-1:0] ex_Rfile_wn,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  memwb_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  mem_err,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_count,
`endif
  output logic [1:0]            ctrl_state
);

  ctrl_state_t      state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             lu;
  logic             mem_stall;
  logic             timeout;
  logic             hold;
  logic             do_br;
  logic             do_lu;
  logic             do_run;

  hazard_detect u_hd (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_MemRead  (ex_MemRead),
    .ex_Rfile_wn (ex_Rfile_wn),
    .lu          (lu)
  );

  assign mem_stall = mem_req & ~mem_ready & (state != ERR);
  assign cnt_nxt   = wait_cnt + CNT_W'(1);
  assign timeout   = mem_stall & (cnt_nxt == CNT_W'(MEM_TIMEOUT));

  // one-hot priority terms: hold > branch > load-use > run
  assign hold   = ~rst | (state == ERR) | mem_stall;
  assign do_br  = ~hold & branch_taken;
  assign do_lu  = ~hold & ~branch_taken & lu;
  assign do_run = ~hold & ~branch_taken & ~lu;

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    unique case (1'b1)
      do_br: begin
        {pc_en, ifid_en, idex_en} = 3'b111;
        {exmem_en, memwb_en}      = 2'b11;
        ifid_flush                = 1'b1;
        idex_flush                = 1'b1;
      end
      do_lu: begin
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        idex_flush = 1'b1;
      end
      do_run: begin
        {pc_en, ifid_en, idex_en} = 3'b111;
        {exmem_en, memwb_en}      = 2'b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
      mem_err  <= 1'b0;
    end else begin
      unique case (state)
        RUN, MEM_WAIT: begin
          if (timeout) begin
            state    <= ERR;
            wait_cnt <= cnt_nxt;
            mem_err  <= 1'b1;
          end else if (mem_stall) begin
            state    <= MEM_WAIT;
            wait_cnt <= cnt_nxt;
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ctrl_state = state;

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pc_en && state != ERR && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (ifid_flush && flush_count != '1)
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule
